// File: rtl/uart_word_assembler_pkg.sv
// Shared definitions for the UART RX word assembler.
// Contents:
//   UART_NB_DATA / UART_NB_BYTE : default word and byte widths
//   UART_BYTES_PER_WORD         : number of UART bytes packed into one word
//   collect_state_e             : state of the byte-collection FSM
package uart_word_assembler_pkg;

  localparam int UART_NB_DATA        = 32;
  localparam int UART_NB_BYTE        = 8;
  localparam int UART_BYTES_PER_WORD = UART_NB_DATA / UART_NB_BYTE;

  // IDLE always means no partial word is held (byte count is zero).
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } collect_state_e;

endpackage

// File: rtl/uart_word_assembler_if.sv
// Byte-in / word-out bus of the UART RX word assembler.
// Signals:
//   i_byte       : received UART byte, valid only with i_byte_done
//   i_byte_done  : 1-cycle pulse marking i_byte valid
//   i_word_ready : consumer accepts o_word when o_word_valid is also high
//   o_word       : assembled word, stable while o_word_valid
//   o_word_valid : output register holds an unconsumed word
// Modports:
//   master : UART receiver plus word consumer side (drives bytes and ready)
//   slave  : the assembler itself
interface uart_word_assembler_if
  import uart_word_assembler_pkg::*;
#(
  parameter int NB_DATA = UART_NB_DATA,
  parameter int NB_BYTE = UART_NB_BYTE
);

  logic [NB_BYTE-1:0] i_byte;
  logic               i_byte_done;
  logic               i_word_ready;
  logic [NB_DATA-1:0] o_word;
  logic               o_word_valid;

  modport master (
    output i_byte,
    output i_byte_done,
    output i_word_ready,
    input  o_word,
    input  o_word_valid
  );

  modport slave (
    input  i_byte,
    input  i_byte_done,
    input  i_word_ready,
    output o_word,
    output o_word_valid
  );

endinterface

// File: rtl/uart_word_assembler_rx_timeout_counter.sv
// Inter-byte idle timer for the UART RX word assembler.
// Ports:
//   i_clock  : core clock
//   i_reset  : synchronous, active-high reset
//   i_clear  : restart the idle count from zero (has priority over i_enable)
//   i_enable : count idle cycles
//   o_expire : high while enabled and the count has reached TIMEOUT_CYCLES-1
module uart_rx_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Saturate at the expiry value so the count can never wrap back to zero.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable && (count_q != LAST_COUNT)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expire = i_enable && (count_q == LAST_COUNT);

endmodule

// File: rtl/uart_word_assembler.sv
// Packs the UART RX byte stream into NB_DATA-bit words for the debug unit.
// A partial word that sees no new byte for TIMEOUT_CYCLES clocks is discarded,
// and completed words are presented through a one-word valid/ready register.
// Ports:
//   i_clock, i_reset  : core clock, synchronous active-high reset
//   i_flush           : clears partial word, output register and error flag
//   bus               : byte input and word valid/ready output (slave side)
//   o_busy            : partial word pending
//   o_byte_count      : bytes collected in the current partial word
//   o_timeout_pulse   : 1-cycle pulse, partial word discarded by timeout
//   o_overflow_pulse  : 1-cycle pulse, completed word dropped (output full)
//   o_error           : sticky timeout/overflow flag
module uart_word_assembler
  import uart_word_assembler_pkg::*;
#(
  parameter int NB_DATA        = UART_NB_DATA,
  parameter int NB_BYTE        = UART_NB_BYTE,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int LSB_FIRST      = 1
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_flush,
  uart_word_assembler_if.slave   bus,
  output logic                   o_busy,
  output logic [2:0]             o_byte_count,
  output logic                   o_timeout_pulse,
  output logic                   o_overflow_pulse,
  output logic                   o_error
);

  localparam int         BYTES_PER_WORD = NB_DATA / NB_BYTE;
  localparam logic [2:0] LAST_SLOT      = 3'(BYTES_PER_WORD - 1);

  collect_state_e     state_q, state_d;
  logic [2:0]         count_q, count_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_DATA-1:0] word_q, word_d;
  logic               valid_q, valid_d;
  logic               timeout_pulse_q, timeout_pulse_d;
  logic               overflow_pulse_q, overflow_pulse_d;
  logic               error_q, error_d;

  logic [NB_DATA-1:0] assembled;
  logic               consume;
  logic               expire;
  logic               tmr_clear;
  logic               tmr_enable;

  // The idle timer only runs while a partial word is held; any byte, flush
  // or return to IDLE restarts it.
  always_comb begin
    tmr_enable = (state_q == ST_COLLECT);
    tmr_clear  = i_flush || bus.i_byte_done || (state_q != ST_COLLECT);
  end

  uart_rx_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (tmr_clear),
    .i_enable (tmr_enable),
    .o_expire (expire)
  );

  // Current partial word with the incoming byte dropped into the slot selected
  // by the byte count; slot 0 is the low byte when LSB_FIRST, else the high byte.
  always_comb begin
    assembled = shift_q;
    for (int s = 0; s < BYTES_PER_WORD; s++) begin
      if (count_q == 3'(s)) begin
        if (LSB_FIRST != 0) begin
          assembled[s*NB_BYTE +: NB_BYTE] = bus.i_byte;
        end else begin
          assembled[NB_DATA-1-s*NB_BYTE -: NB_BYTE] = bus.i_byte;
        end
      end
    end
  end

  // Collection FSM plus output register. A completed word is loaded when the
  // register is empty or being emptied this same cycle; otherwise it is dropped.
  // A byte arriving in the expiry cycle takes precedence over the timeout.
  always_comb begin
    state_d          = state_q;
    count_d          = count_q;
    shift_d          = shift_q;
    word_d           = word_q;
    valid_d          = valid_q;
    timeout_pulse_d  = 1'b0;
    overflow_pulse_d = 1'b0;
    error_d          = error_q;

    consume = valid_q && bus.i_word_ready;
    if (consume) begin
      valid_d = 1'b0;
    end

    if (bus.i_byte_done) begin
      if (count_q == LAST_SLOT) begin
        state_d = ST_IDLE;
        count_d = '0;
        shift_d = '0;
        if (!valid_q || consume) begin
          word_d  = assembled;
          valid_d = 1'b1;
        end else begin
          overflow_pulse_d = 1'b1;
          error_d          = 1'b1;
        end
      end else begin
        state_d = ST_COLLECT;
        count_d = count_q + 3'd1;
        shift_d = assembled;
      end
    end else if ((state_q == ST_COLLECT) && expire) begin
      state_d         = ST_IDLE;
      count_d         = '0;
      shift_d         = '0;
      timeout_pulse_d = 1'b1;
      error_d         = 1'b1;
    end

    if (i_flush) begin
      state_d          = ST_IDLE;
      count_d          = '0;
      shift_d          = '0;
      word_d           = '0;
      valid_d          = 1'b0;
      timeout_pulse_d  = 1'b0;
      overflow_pulse_d = 1'b0;
      error_d          = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q          <= ST_IDLE;
      count_q          <= '0;
      shift_q          <= '0;
      word_q           <= '0;
      valid_q          <= 1'b0;
      timeout_pulse_q  <= 1'b0;
      overflow_pulse_q <= 1'b0;
      error_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      count_q          <= count_d;
      shift_q          <= shift_d;
      word_q           <= word_d;
      valid_q          <= valid_d;
      timeout_pulse_q  <= timeout_pulse_d;
      overflow_pulse_q <= overflow_pulse_d;
      error_q          <= error_d;
    end
  end

  assign bus.o_word       = word_q;
  assign bus.o_word_valid = valid_q;
  assign o_busy           = (count_q != 3'd0);
  assign o_byte_count     = count_q;
  assign o_timeout_pulse  = timeout_pulse_q;
  assign o_overflow_pulse = overflow_pulse_q;
  assign o_error          = error_q;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Self-checking bench for uart_word_assembler. Two instances (LSB-first and
// MSB-first, short timeout) receive identical stimulus and are compared every
// cycle against a byte-queue reference model, with directed scenarios first and
// a randomized byte/gap/ready/flush stream afterwards.
module tb_uart_word_assembler;

  localparam int T = 16;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  uart_word_assembler_if #(.NB_DATA(32), .NB_BYTE(8)) lsb_bus ();
  uart_word_assembler_if #(.NB_DATA(32), .NB_BYTE(8)) msb_bus ();

  logic       lsb_busy, lsb_to, lsb_ov, lsb_err;
  logic [2:0] lsb_count;
  logic       msb_busy, msb_to, msb_ov, msb_err;
  logic [2:0] msb_count;

  uart_word_assembler #(
    .NB_DATA(32), .NB_BYTE(8), .TIMEOUT_CYCLES(T), .LSB_FIRST(1)
  ) dut_lsb (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_flush          (flush),
    .bus              (lsb_bus.slave),
    .o_busy           (lsb_busy),
    .o_byte_count     (lsb_count),
    .o_timeout_pulse  (lsb_to),
    .o_overflow_pulse (lsb_ov),
    .o_error          (lsb_err)
  );

  uart_word_assembler #(
    .NB_DATA(32), .NB_BYTE(8), .TIMEOUT_CYCLES(T), .LSB_FIRST(0)
  ) dut_msb (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_flush          (flush),
    .bus              (msb_bus.slave),
    .o_busy           (msb_busy),
    .o_byte_count     (msb_count),
    .o_timeout_pulse  (msb_to),
    .o_overflow_pulse (msb_ov),
    .o_error          (msb_err)
  );

  int test_count = 0;
  int fail_count = 0;

  // Reference model: bytes of the pending word, idle cycles since the last
  // byte, the word held for the consumer (both byte orders) and flag state.
  logic [7:0]  m_part[$];
  int          m_idle = 0;
  logic [31:0] m_word_lsb = '0;
  logic [31:0] m_word_msb = '0;
  bit          m_valid = 0;
  bit          m_timeout = 0;
  bit          m_overflow = 0;
  bit          m_error = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic modelStep(input bit done, input logic [7:0] b, input bit rdy,
                           input bit fl, input bit rs);
    logic [31:0] w_lsb;
    logic [31:0] w_msb;
    m_timeout  = 0;
    m_overflow = 0;
    if (rs || fl) begin
      m_part.delete();
      m_idle     = 0;
      m_word_lsb = '0;
      m_word_msb = '0;
      m_valid    = 0;
      m_error    = 0;
      return;
    end
    if (m_valid && rdy) m_valid = 0;
    if (done) begin
      m_part.push_back(b);
      m_idle = 0;
      if (m_part.size() == 4) begin
        w_lsb = '0;
        w_msb = '0;
        for (int i = 0; i < 4; i++) begin
          w_lsb = w_lsb | (32'(m_part[i]) << (8 * i));
          w_msb = w_msb | (32'(m_part[i]) << (8 * (3 - i)));
        end
        m_part.delete();
        if (!m_valid) begin
          m_valid    = 1;
          m_word_lsb = w_lsb;
          m_word_msb = w_msb;
        end else begin
          m_overflow = 1;
          m_error    = 1;
        end
      end
    end else if (m_part.size() != 0) begin
      if (m_idle == T - 1) begin
        m_part.delete();
        m_idle    = 0;
        m_timeout = 1;
        m_error   = 1;
      end else begin
        m_idle++;
      end
    end
  endtask

  task automatic checkDut(input string pfx, input logic [31:0] word, input logic valid,
                          input logic busy, input logic [2:0] cnt, input logic to,
                          input logic ov, input logic er, input logic [31:0] exp_word);
    checkOutput({pfx, "_valid"}, 32'(valid), 32'(m_valid));
    if (m_valid) checkOutput({pfx, "_word"}, word, exp_word);
    checkOutput({pfx, "_busy"}, 32'(busy), 32'(m_part.size() != 0));
    checkOutput({pfx, "_count"}, 32'(cnt), 32'(m_part.size()));
    checkOutput({pfx, "_timeout"}, 32'(to), 32'(m_timeout));
    checkOutput({pfx, "_overflow"}, 32'(ov), 32'(m_overflow));
    checkOutput({pfx, "_error"}, 32'(er), 32'(m_error));
  endtask

  // One clock: drive inputs on the falling edge, advance the model, then
  // compare both instances shortly after the rising edge.
  task automatic applyStimulus(input bit done, input logic [7:0] b, input bit rdy,
                               input bit fl, input bit rs);
    @(negedge clk);
    lsb_bus.i_byte_done  = done;
    lsb_bus.i_byte       = b;
    lsb_bus.i_word_ready = rdy;
    msb_bus.i_byte_done  = done;
    msb_bus.i_byte       = b;
    msb_bus.i_word_ready = rdy;
    flush = fl;
    rst   = rs;
    modelStep(done, b, rdy, fl, rs);
    @(posedge clk);
    #1;
    checkDut("lsb", lsb_bus.o_word, lsb_bus.o_word_valid, lsb_busy, lsb_count,
             lsb_to, lsb_ov, lsb_err, m_word_lsb);
    checkDut("msb", msb_bus.o_word, msb_bus.o_word_valid, msb_busy, msb_count,
             msb_to, msb_ov, msb_err, m_word_msb);
  endtask

  task automatic sendByte(input logic [7:0] b, input bit rdy);
    applyStimulus(1'b1, b, rdy, 1'b0, 1'b0);
  endtask

  task automatic idleCycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, rdy, 1'b0, 1'b0);
  endtask

  task automatic doFlush();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    lsb_bus.i_byte_done = 1'b0; lsb_bus.i_byte = '0; lsb_bus.i_word_ready = 1'b0;
    msb_bus.i_byte_done = 1'b0; msb_bus.i_byte = '0; msb_bus.i_word_ready = 1'b0;

    // Reset state
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("reset_word", lsb_bus.o_word, 32'h0);
    checkOutput("reset_valid", 32'(lsb_bus.o_word_valid), 32'h0);

    // Byte ordering, consumer always ready
    sendByte(8'h78, 1'b1); sendByte(8'h56, 1'b1); sendByte(8'h34, 1'b1); sendByte(8'h12, 1'b1);
    checkOutput("order_lsb_word", lsb_bus.o_word, 32'h12345678);
    checkOutput("order_msb_word", msb_bus.o_word, 32'h78563412);
    checkOutput("order_valid", 32'(lsb_bus.o_word_valid), 32'h1);
    idleCycles(1, 1'b1);

    // Overflow while the held word is not consumed
    sendByte(8'h44, 1'b0); sendByte(8'h33, 1'b0); sendByte(8'h22, 1'b0); sendByte(8'h11, 1'b0);
    sendByte(8'h88, 1'b0); sendByte(8'h77, 1'b0); sendByte(8'h66, 1'b0); sendByte(8'h55, 1'b0);
    checkOutput("ovf_pulse", 32'(lsb_ov), 32'h1);
    checkOutput("ovf_error", 32'(lsb_err), 32'h1);
    checkOutput("ovf_word_held", lsb_bus.o_word, 32'h11223344);
    idleCycles(1, 1'b1);
    checkOutput("ovf_drained", 32'(lsb_bus.o_word_valid), 32'h0);

    // Timeout of a two-byte partial word, then a clean word
    doFlush();
    sendByte(8'hE1, 1'b0); sendByte(8'hE2, 1'b0);
    idleCycles(T - 1, 1'b0);
    checkOutput("to_not_yet", 32'(lsb_to), 32'h0);
    idleCycles(1, 1'b0);
    checkOutput("to_pulse", 32'(lsb_to), 32'h1);
    checkOutput("to_count", 32'(lsb_count), 32'h0);
    idleCycles(1, 1'b0);
    checkOutput("to_once", 32'(lsb_to), 32'h0);
    sendByte(8'hAA, 1'b0); sendByte(8'hBB, 1'b0); sendByte(8'hCC, 1'b0); sendByte(8'hDD, 1'b0);
    checkOutput("to_clean_word", lsb_bus.o_word, 32'hDDCCBBAA);

    // Byte on the expiry cycle wins
    doFlush();
    sendByte(8'h01, 1'b0);
    idleCycles(T - 1, 1'b0);
    sendByte(8'h02, 1'b0);
    checkOutput("edge_count", 32'(lsb_count), 32'h2);
    checkOutput("edge_no_timeout", 32'(lsb_to), 32'h0);

    // Completion in the same cycle as consumption
    doFlush();
    sendByte(8'hA1, 1'b0); sendByte(8'hA2, 1'b0); sendByte(8'hA3, 1'b0); sendByte(8'hA4, 1'b0);
    sendByte(8'hB1, 1'b0); sendByte(8'hB2, 1'b0); sendByte(8'hB3, 1'b0);
    sendByte(8'hB4, 1'b1);
    checkOutput("handoff_valid", 32'(lsb_bus.o_word_valid), 32'h1);
    checkOutput("handoff_word", lsb_bus.o_word, 32'hB4B3B2B1);
    checkOutput("handoff_no_ovf", 32'(lsb_ov), 32'h0);

    // Reset together with flush, then flush alone, from a loaded state
    sendByte(8'hC1, 1'b0); sendByte(8'hC2, 1'b0); sendByte(8'hC3, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    checkOutput("rstflush_word", lsb_bus.o_word, 32'h0);
    checkOutput("rstflush_count", 32'(lsb_count), 32'h0);
    sendByte(8'hD1, 1'b0); sendByte(8'hD2, 1'b0); sendByte(8'hD3, 1'b0); sendByte(8'hD4, 1'b0);
    sendByte(8'hD5, 1'b0); sendByte(8'hD6, 1'b0); sendByte(8'hD7, 1'b0);
    doFlush();
    checkOutput("flush_word", msb_bus.o_word, 32'h0);
    checkOutput("flush_valid", 32'(msb_bus.o_word_valid), 32'h0);

    // Randomized gaps (some past the timeout), ready and rare flushes
    for (int n = 0; n < 400; n++) begin
      int gap;
      gap = int'($urandom_range(0, 20));
      for (int g = 0; g < gap; g++) begin
        applyStimulus(1'b0, 8'h00, ($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 99) == 0), 1'b0);
      end
      sendByte(8'($urandom), ($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
